// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - USB RX bit timing, resync and destuffing; optional stuffing via USB_RX_BIT_STUFF_EN
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_POINT  = 3,
    parameter int BITS_PER_BYTE = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable_timer,
    input  logic       d_edge,
    input  logic       d_orig,
    output logic       shift_enable,
    output logic       byte_received,
    output logic [2:0] bit_count,
    output logic       stuff_error
);

    localparam int              CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
    localparam logic [2:0]       BIT_LAST   = 3'(BITS_PER_BYTE - 1);

    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_cnt_nxt;
    logic [2:0]       bit_count_nxt;
    logic             last_bit;
    logic             last_bit_nxt;
    logic             shift_nxt;
    logic             byte_nxt;
    logic             sample;
    logic             stuffed;

    // A resync edge wins over a sample landing in the same cycle.
    assign sample = enable_timer && !d_edge && (clk_cnt == CNT_SAMPLE);

`ifdef USB_RX_BIT_STUFF_EN
    logic [2:0] ones_cnt;
    logic [2:0] ones_cnt_nxt;
    logic       err_nxt;

    assign stuffed = (ones_cnt == 3'd6);

    // Run of decoded 1s; survives byte boundaries so stuffing can span bytes.
    always_comb begin
        ones_cnt_nxt = ones_cnt;
        err_nxt      = 1'b0;
        if (!enable_timer) begin
            ones_cnt_nxt = 3'd0;
        end else if (sample) begin
            if (stuffed) begin
                ones_cnt_nxt = 3'd0;
                err_nxt      = d_orig;
            end else if (d_orig) begin
                ones_cnt_nxt = (ones_cnt == 3'd6) ? 3'd6 : ones_cnt + 3'd1;
            end else begin
                ones_cnt_nxt = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_cnt    <= 3'd0;
            stuff_error <= 1'b0;
        end else begin
            ones_cnt    <= ones_cnt_nxt;
            stuff_error <= err_nxt;
        end
    end
`else
    assign stuffed     = 1'b0;
    assign stuff_error = 1'b0;
`endif

    always_comb begin
        clk_cnt_nxt   = clk_cnt;
        bit_count_nxt = bit_count;
        last_bit_nxt  = 1'b0;
        shift_nxt     = 1'b0;
        byte_nxt      = 1'b0;
        if (!enable_timer) begin
            clk_cnt_nxt   = '0;
            bit_count_nxt = 3'd0;
        end else begin
            if (d_edge || (clk_cnt == CNT_LAST)) begin
                clk_cnt_nxt = '0;
            end else begin
                clk_cnt_nxt = clk_cnt + CNT_W'(1);
            end
            // byte_received trails the final shift so the shifter already holds bit 8.
            byte_nxt = last_bit;
            if (sample && !stuffed) begin
                shift_nxt     = 1'b1;
                last_bit_nxt  = (bit_count == BIT_LAST);
                bit_count_nxt = (bit_count == BIT_LAST) ? 3'd0 : bit_count + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt       <= '0;
            bit_count     <= 3'd0;
            last_bit      <= 1'b0;
            shift_enable  <= 1'b0;
            byte_received <= 1'b0;
        end else begin
            clk_cnt       <= clk_cnt_nxt;
            bit_count     <= bit_count_nxt;
            last_bit      <= last_bit_nxt;
            shift_enable  <= shift_nxt;
            byte_received <= byte_nxt;
        end
    end

endmodule
